// File: rtl/series_arb_pkg.sv
// Shared types and helpers for the series-engine arbiter and related multi-client blocks.
package series_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    DONE   = 3'd3,
    COOL   = 3'd4
  } arb_state_t;

  localparam int XW_DEF      = 8;
  localparam int RW_DEF      = 16;
  localparam int TIMEOUT_DEF = 1024;
  localparam int WD_W        = $clog2(TIMEOUT_DEF);

  // Client index reached by stepping 'offset' places past 'base' in a ring of n clients.
  function automatic int rr_index(input int base, input int offset, input int n);
    return (base + offset) % n;
  endfunction

endpackage

// File: rtl/series_engine_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: the requester at ptr has top priority,
// then ptr+1, ptr+2, ... wrapping around the ring of N clients.
module rr_picker
  import series_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          valid,
  output logic [PW-1:0] winner
);

  assign valid = |req;

  // Scan from the farthest offset down to ptr itself so the closest requester is written last and wins.
  always_comb begin
    winner = '0;
    for (int i = N - 1; i >= 0; i--) begin
      winner = req[rr_index(int'(ptr), i, N)] ? PW'(rr_index(int'(ptr), i, N)) : winner;
    end
  end

endmodule

// File: rtl/series_engine_arbiter.sv
// Shares one series-evaluation engine among N_REQ clients: round-robin grant, engine
// launch/wait handshake, watchdog abort, and a one-cycle ack carrying result/err.
module series_engine_arbiter
  import series_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int XW      = XW_DEF,
  parameter int RW      = RW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*XW-1:0]      x_in,
  output logic [N_REQ-1:0]         ack,
  output logic [RW-1:0]            result,
  output logic                     err,
  output logic                     busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     eng_start,
  output logic [XW-1:0]            eng_x,
  input  logic                     eng_ready,
  input  logic [RW-1:0]            eng_result
);

  localparam int GW  = $clog2(N_REQ);
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0]   WD_LAST  = WDW'(TIMEOUT - 1);
  localparam logic [GW-1:0]    GID_LAST = GW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1'b1);

  arb_state_t     state_r;
  arb_state_t     state_s;
  logic [GW-1:0]  ptr_r;
  logic [WDW-1:0] wd_r;
  logic           pick_valid_s;
  logic [GW-1:0]  pick_winner_s;
  logic           timeout_s;

  rr_picker #(
    .N  (N_REQ),
    .PW (GW)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_r),
    .valid  (pick_valid_s),
    .winner (pick_winner_s)
  );

  // Watchdog expires on the cycle whose count has reached TIMEOUT-1; it outranks completion.
  assign timeout_s = (wd_r == WD_LAST);

  // Next-state selection for the grant/launch/run/ack/cool-down sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_valid_s) begin
          state_s = LAUNCH;
        end else begin
          state_s = IDLE;
        end
      end
      LAUNCH: begin
        if (timeout_s) begin
          state_s = DONE;
        end else if (!eng_ready) begin
          state_s = RUN;
        end else begin
          state_s = LAUNCH;
        end
      end
      RUN: begin
        if (timeout_s || eng_ready) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = COOL;
      COOL:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register; a reset mid-job simply abandons the job without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Grant/operand capture, engine start, watchdog, result/err capture, ack pulse and rr pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack       <= '0;
      result    <= '0;
      err       <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= '0;
      eng_start <= 1'b0;
      eng_x     <= '0;
      ptr_r     <= '0;
      wd_r      <= '0;
    end else begin
      ack  <= '0;
      busy <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (pick_valid_s) begin
            grant_id  <= pick_winner_s;
            eng_x     <= x_in[pick_winner_s*XW +: XW];
            wd_r      <= '0;
            eng_start <= 1'b1;
          end
        end
        LAUNCH: begin
          if (timeout_s) begin
            result    <= '0;
            err       <= 1'b1;
            ack       <= ONE_HOT0 << grant_id;
            eng_start <= 1'b0;
          end else begin
            wd_r <= wd_r + WDW'(1);
            if (!eng_ready) begin
              eng_start <= 1'b0;
            end
          end
        end
        RUN: begin
          if (timeout_s) begin
            result <= '0;
            err    <= 1'b1;
            ack    <= ONE_HOT0 << grant_id;
          end else if (eng_ready) begin
            result <= eng_result;
            err    <= 1'b0;
            ack    <= ONE_HOT0 << grant_id;
          end else begin
            wd_r <= wd_r + WDW'(1);
          end
        end
        DONE: begin
          ptr_r <= (grant_id == GID_LAST) ? '0 : grant_id + GW'(1);
        end
        default: begin
          ptr_r <= ptr_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_series_engine_arbiter.sv
// Self-checking bench: behavioural engine (ready drops 1 cycle after start, rises D cycles
// later, result = 3*x) and a transaction-level model of grant order, latency and outcome.
module tb_series_engine_arbiter;

  localparam int N  = 4;
  localparam int XW = 8;
  localparam int RW = 16;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*XW-1:0] x_in;
  logic [N-1:0]    ack;
  logic [RW-1:0]   result;
  logic            err;
  logic            busy;
  logic [1:0]      grant_id;
  logic            eng_start;
  logic [XW-1:0]   eng_x;
  logic            eng_ready;
  logic [RW-1:0]   eng_result;

  logic [XW-1:0] xs [N];
  int            eng_d;
  logic          eng_abort;
  int            eng_cnt;
  logic [XW-1:0] eng_xl;

  int         cyc;
  int         n_tests;
  int         n_fail;
  int         ack_seen;
  int         ack_bad;
  logic [N-1:0] prev_ack;
  int         ptr_m;
  int         ack_exp;
  int         last_ack_cyc;
  int         last_w;

  series_engine_arbiter #(
    .N_REQ   (N),
    .XW      (XW),
    .RW      (RW),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .x_in       (x_in),
    .ack        (ack),
    .result     (result),
    .err        (err),
    .busy       (busy),
    .grant_id   (grant_id),
    .eng_start  (eng_start),
    .eng_x      (eng_x),
    .eng_ready  (eng_ready),
    .eng_result (eng_result)
  );

  always #5 clk = ~clk;

  // Pack per-client operands onto the flat bus.
  always_comb begin
    x_in = '0;
    for (int i = 0; i < N; i++) x_in[i*XW +: XW] = xs[i];
  end

  // Cycle counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural engine sharing rst with the arbiter; eng_abort models an external kill of a hung job.
  always @(posedge clk) begin
    if (rst) begin
      eng_ready  <= 1'b1;
      eng_cnt    <= 0;
      eng_result <= '0;
      eng_xl     <= '0;
    end else if (eng_abort) begin
      eng_ready <= 1'b1;
    end else if (eng_ready) begin
      if (eng_start) begin
        eng_ready <= 1'b0;
        eng_cnt   <= eng_d;
        eng_xl    <= eng_x;
      end
    end else if (eng_cnt == 1) begin
      eng_ready  <= 1'b1;
      eng_result <= 16'(eng_xl) * 16'd3;
    end else begin
      eng_cnt <= eng_cnt - 1;
    end
  end

  // Counts ack pulses and flags any ack that is not one-hot or lasts more than one cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_ack <= '0;
    end else begin
      if (ack != '0) begin
        ack_seen <= ack_seen + 1;
        if ($countones(ack) != 1 || prev_ack != '0) ack_bad <= ack_bad + 1;
      end
      prev_ack <= ack;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Round-robin rule: first requesting client at or after the pointer, wrapping.
  function automatic int model_pick();
    int w;
    w = -1;
    for (int i = 0; i < N; i++) begin
      if (w < 0 && req[(ptr_m + i) % N]) w = (ptr_m + i) % N;
    end
    return w;
  endfunction

  // One job from request to the cycle after ack; called and returning on a negedge.
  task automatic serve_one(input int d, input bit chained);
    int w, k, t0, t1, lat_exp;
    bit to_exp;
    logic [RW-1:0] res_exp;
    eng_d   = d;
    w       = model_pick();
    to_exp  = (d + 2 >= TO);
    res_exp = to_exp ? 16'd0 : 16'(xs[w]) * 16'd3;
    lat_exp = to_exp ? TO : d + 2;
    k = 0;
    while (eng_start !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("start_seen", 32'(eng_start), 32'd1);
    t0 = cyc;
    if (chained) check("grant_spacing", t0 - last_ack_cyc, 32'd3);
    check("grant_id", 32'(grant_id), w);
    check("eng_x", 32'(eng_x), 32'(xs[w]));
    check("busy_job", 32'(busy), 32'd1);
    k = 0;
    while (ack === '0 && k < TO + 10) begin
      @(negedge clk);
      k++;
    end
    t1 = cyc;
    check("ack_onehot", 32'(ack), 32'd1 << w);
    check("result", 32'(result), 32'(res_exp));
    check("err", 32'(err), 32'(to_exp));
    check("latency", t1 - t0, lat_exp);
    last_ack_cyc = t1;
    ptr_m        = (w + 1) % N;
    ack_exp++;
    last_w       = w;
    eng_abort    = to_exp;
    @(negedge clk);
    eng_abort = 1'b0;
    check("ack_pulse", 32'(ack), 32'd0);
    check("result_hold", 32'(result), 32'(res_exp));
    check("err_hold", 32'(err), 32'(to_exp));
  endtask

  initial begin
    int k;
    rst          = 1'b1;
    req          = 4'b1111;
    eng_d        = 5;
    eng_abort    = 1'b0;
    ptr_m        = 0;
    ack_exp      = 0;
    last_ack_cyc = 0;
    last_w       = 0;
    for (int i = 0; i < N; i++) xs[i] = XW'($urandom);

    // Reset held two cycles while everyone requests.
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_eng_start", 32'(eng_start), 32'd0);
    check("rst_eng_x", 32'(eng_x), 32'd0);
    rst = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_eng_start", 32'(eng_start), 32'd0);

    // All clients requesting continuously: expect rotation 0,1,2,3,0.
    req = 4'b1111;
    serve_one(int'($urandom_range(1, 12)), 1'b0);
    for (int j = 0; j < 4; j++) begin
      xs[last_w] = XW'($urandom);
      serve_one(int'($urandom_range(1, 12)), 1'b1);
    end

    // Single requester, client 2 with x=5 and D=10, then re-granted alone.
    req   = 4'b0100;
    xs[2] = 8'd5;
    serve_one(10, 1'b1);
    serve_one(3, 1'b1);

    // Hung engine aborted by the watchdog, then boundary completions.
    req   = 4'b0001;
    xs[0] = XW'($urandom);
    serve_one(1000, 1'b1);
    xs[0] = XW'($urandom);
    serve_one(TO - 3, 1'b1);
    xs[0] = XW'($urandom);
    serve_one(TO - 2, 1'b1);

    // Move the pointer to 2, then reset in the middle of the next job.
    req = 4'b0010;
    serve_one(4, 1'b1);
    req = 4'b1111;
    for (int i = 0; i < N; i++) xs[i] = XW'($urandom);
    eng_d = 10;
    k = 0;
    while (eng_start !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("pre_rst_grant", 32'(grant_id), model_pick());
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_eng_start", 32'(eng_start), 32'd0);
    check("midrst_grant_id", 32'(grant_id), 32'd0);
    ptr_m = 0;
    serve_one(6, 1'b0);

    // Randomized traffic: clients join at random, the winner may re-request.
    for (int j = 0; j < 30; j++) begin
      req[last_w] = 1'($urandom_range(0, 1));
      if (req[last_w]) xs[last_w] = XW'($urandom);
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i] = 1'b1;
          xs[i]  = XW'($urandom);
        end
      end
      if (req == '0) begin
        req[0] = 1'b1;
        xs[0]  = XW'($urandom);
      end
      serve_one(int'($urandom_range(1, 16)), 1'b1);
    end

    req = '0;
    repeat (4) @(negedge clk);
    check("ack_count", ack_seen, ack_exp);
    check("ack_shape", ack_bad, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
